// File: rtl/jk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// jk_ctrl_pkg
// Shared types and helpers for the JK cell bank and its command arbiter.
//   jk_op_e      : JK operation encoding {j,k}
//   arb_state_e  : arbiter FSM states
//   jk_apply()   : next value of one JK cell for a given operation
// -----------------------------------------------------------------------------
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    // Characteristic equation of a JK flip-flop, written per operation.
    function automatic logic jk_apply(input logic cur, input jk_op_e op);
        logic nxt;
        case (op)
            JK_HOLD: nxt = cur;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell_bank.sv
// -----------------------------------------------------------------------------
// jk_cell_bank
// A bank of N_CELLS JK flip-flop cells. When we is high, op is applied to the
// cell selected by idx; every other cell holds. An idx that names no cell
// (idx >= N_CELLS) leaves the whole bank unchanged.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears all cells
//   we    : apply op this edge
//   idx   : target cell index
//   op    : JK operation
//   q     : cell states
// -----------------------------------------------------------------------------
module jk_cell_bank
    import jk_ctrl_pkg::*;
#(
    parameter int N_CELLS = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [IDX_W-1:0]   idx,
    input  jk_op_e             op,
    output logic [N_CELLS-1:0] q
);

    logic [N_CELLS-1:0] r_q;
    logic [N_CELLS-1:0] w_q_next;

    // Next-state of every cell: only the addressed cell may change.
    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < N_CELLS; i++) begin
            if (we && (idx == IDX_W'(i))) begin
                w_q_next[i] = jk_apply(r_q[i], op);
            end else begin
                w_q_next[i] = r_q[i];
            end
        end
    end

    // Cell storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= {N_CELLS{1'b0}};
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter
// Shares a bank of JK cells between two command requesters. A round-robin
// arbiter picks one requester while idle; the accepted command's op is then
// applied to its cell on cnt+1 consecutive clocks, followed by a done pulse.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   reqN_valid / reqN_ready    : command handshake for requester N (0,1)
//   reqN_idx, reqN_jk, reqN_cnt: target cell, {j,k} op, extra repeats
//   q, qn                      : cell states and their inverse
//   busy                       : command in progress
//   grant_id                   : owner of the active command (valid when busy)
//   done                       : one-cycle pulse after the final application
// -----------------------------------------------------------------------------
module jk_bank_arbiter
    import jk_ctrl_pkg::*;
#(
    parameter  int N_CELLS = 8,
    parameter  int CNT_W   = 4,
    localparam int IDX_W   = $clog2(N_CELLS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [IDX_W-1:0]   req0_idx,
    input  logic [1:0]         req0_jk,
    input  logic [CNT_W-1:0]   req0_cnt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [IDX_W-1:0]   req1_idx,
    input  logic [1:0]         req1_jk,
    input  logic [CNT_W-1:0]   req1_cnt,
    output logic [N_CELLS-1:0] q,
    output logic [N_CELLS-1:0] qn,
    output logic               busy,
    output logic               grant_id,
    output logic               done
);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        jk_op_e           op;
        logic [CNT_W-1:0] cnt;
    } cmd_t;

    arb_state_e         r_state;
    arb_state_e         w_state_next;
    cmd_t               r_cmd;
    logic               r_ptr;
    logic               r_grant_id;
    logic               r_done;
    logic               w_done_next;
    logic               w_grant;
    logic               w_idle;
    logic               w_accept;
    logic               w_we;
    cmd_t               w_cmd0;
    cmd_t               w_cmd1;
    cmd_t               w_sel_cmd;
    logic [N_CELLS-1:0] w_q;

    assign w_idle = (r_state == ST_IDLE);
    assign w_we   = (r_state == ST_RUN);

    // Round-robin choice: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        w_grant = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = r_ptr;
            default: w_grant = 1'b0;
        endcase
    end

    // Ready includes valid so that at most one requester sees ready at a time.
    assign req0_ready = w_idle & req0_valid & ~w_grant;
    assign req1_ready = w_idle & req1_valid &  w_grant;
    assign w_accept   = req0_ready | req1_ready;

    assign w_cmd0    = '{idx: req0_idx, op: jk_op_e'(req0_jk), cnt: req0_cnt};
    assign w_cmd1    = '{idx: req1_idx, op: jk_op_e'(req1_jk), cnt: req1_cnt};
    assign w_sel_cmd = w_grant ? w_cmd1 : w_cmd0;

    // FSM next state; done is raised on the edge of the last application.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cmd.cnt == {CNT_W{1'b0}}) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command latch, remaining-count decrement, pointer, owner and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd      <= '{idx: {IDX_W{1'b0}}, op: JK_HOLD, cnt: {CNT_W{1'b0}}};
            r_ptr      <= 1'b0;
            r_grant_id <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_accept) begin
                r_cmd      <= w_sel_cmd;
                r_grant_id <= w_grant;
                r_ptr      <= ~w_grant;
            end else if (w_we && (r_cmd.cnt != {CNT_W{1'b0}})) begin
                r_cmd.cnt <= r_cmd.cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cmd <= r_cmd;
            end
        end
    end

    jk_cell_bank #(
        .N_CELLS (N_CELLS),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .idx   (r_cmd.idx),
        .op    (r_cmd.op),
        .q     (w_q)
    );

    assign q        = w_q;
    assign qn       = ~w_q;
    assign busy     = (r_state == ST_RUN);
    assign grant_id = r_grant_id;
    assign done     = r_done;

endmodule
